// File: rtl/uart_pkg.sv
// Shared types and baud-rate helpers for the UART receive path.
// The divisor constants are the 100 MHz values; baud_div() derives them for any clock.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam int unsigned DIV_W = 16;

    localparam logic [DIV_W-1:0] DIV_4800  = 16'd1302;
    localparam logic [DIV_W-1:0] DIV_9600  = 16'd651;
    localparam logic [DIV_W-1:0] DIV_19200 = 16'd326;
    localparam logic [DIV_W-1:0] DIV_38400 = 16'd163;

    // Clocks per 16x tick, rounded to nearest: (f + 8*baud) / (16*baud).
    function automatic logic [DIV_W-1:0] baud_div(input logic [1:0] br_cfg,
                                                  input int unsigned clk_freq_hz);
        int unsigned baud;
        case (br_cfg)
            2'b00:   baud = 32'd4800;
            2'b01:   baud = 32'd9600;
            2'b10:   baud = 32'd19200;
            2'b11:   baud = 32'd38400;
            default: baud = 32'd9600;
        endcase
        return DIV_W'((clk_freq_hz + 32'd8 * baud) / (32'd16 * baud));
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Programmable tick divider: one-clock tick every div_sel clocks while run is high.
// Pass a 1x terminal count instead of the 16x one to reuse it on the transmit side.
module uart_baud_tick
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div_sel,
    input  logic             run,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_r;
    logic             at_tc_s;

    assign at_tc_s = (cnt_r == (div_sel - DIV_W'(1)));

    // Divider count and registered tick; held cleared whenever run is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {DIV_W{1'b0}};
            tick  <= 1'b0;
        end else if (!run) begin
            cnt_r <= {DIV_W{1'b0}};
            tick  <= 1'b0;
        end else if (at_tc_s) begin
            cnt_r <= {DIV_W{1'b0}};
            tick  <= 1'b1;
        end else begin
            cnt_r <= cnt_r + DIV_W'(1);
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, baud select latched per frame,
// and a one-entry valid/ready holding register with framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100000000,
    parameter int unsigned OVERSAMPLE  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic [1:0] br_cfg,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam logic [3:0] OS_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] OS_LAST = 4'(OVERSAMPLE - 1);

    rx_state_e        state_r, state_s;
    logic             rxd_meta_r, rxd_sync_r;
    logic [3:0]       os_cnt_r;
    logic [2:0]       bit_cnt_r;
    logic [7:0]       shift_r;
    logic [DIV_W-1:0] div_r;
    logic             tick_s, run_s;
    logic             os_clr_s, os_inc_s, bit_clr_s, bit_inc_s, shift_en_s;
    logic             latch_div_s, byte_done_s, ferr_s;

    assign run_s = (state_r != IDLE);

    uart_baud_tick u_tick (
        .clk     (clk),
        .rst     (rst),
        .div_sel (div_r),
        .run     (run_s),
        .tick    (tick_s)
    );

    // Two-flop synchronizer; reset to the idle-high line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
        end else begin
            rxd_meta_r <= rxd;
            rxd_sync_r <= rxd_meta_r;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and datapath strobes; all sampling happens on oversample ticks.
    always_comb begin
        state_s     = state_r;
        os_clr_s    = 1'b0;
        os_inc_s    = 1'b0;
        bit_clr_s   = 1'b0;
        bit_inc_s   = 1'b0;
        shift_en_s  = 1'b0;
        latch_div_s = 1'b0;
        byte_done_s = 1'b0;
        ferr_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (!rxd_sync_r) begin
                    state_s     = START;
                    latch_div_s = 1'b1;
                    os_clr_s    = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (tick_s && (os_cnt_r == OS_MID)) begin
                    os_clr_s  = 1'b1;
                    bit_clr_s = 1'b1;
                    state_s   = rxd_sync_r ? IDLE : DATA;
                end else if (tick_s) begin
                    os_inc_s = 1'b1;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (tick_s && (os_cnt_r == OS_LAST)) begin
                    os_clr_s   = 1'b1;
                    shift_en_s = 1'b1;
                    bit_inc_s  = 1'b1;
                    state_s    = (bit_cnt_r == 3'd7) ? STOP : DATA;
                end else if (tick_s) begin
                    os_inc_s = 1'b1;
                end else begin
                    state_s = DATA;
                end
            end
            STOP: begin
                if (tick_s && (os_cnt_r == OS_LAST)) begin
                    os_clr_s    = 1'b1;
                    state_s     = IDLE;
                    byte_done_s = rxd_sync_r;
                    ferr_s      = ~rxd_sync_r;
                end else if (tick_s) begin
                    os_inc_s = 1'b1;
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Oversample/bit counters, shift register and per-frame divisor latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            os_cnt_r  <= 4'd0;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            div_r     <= {DIV_W{1'b0}};
        end else begin
            if (os_clr_s) begin
                os_cnt_r <= 4'd0;
            end else if (os_inc_s) begin
                os_cnt_r <= os_cnt_r + 4'd1;
            end
            if (bit_clr_s) begin
                bit_cnt_r <= 3'd0;
            end else if (bit_inc_s) begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end
            if (shift_en_s) begin
                shift_r <= {rxd_sync_r, shift_r[7:1]};
            end
            if (latch_div_s) begin
                div_r <= baud_div(br_cfg, CLK_FREQ_HZ);
            end
        end
    end

    // Holding register: a same-cycle consume makes room, otherwise a full register overruns.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_s;
            overrun   <= 1'b0;
            if (byte_done_s && (!rx_valid || rx_ready)) begin
                rx_data  <= shift_r;
                rx_valid <= 1'b1;
            end else if (byte_done_s) begin
                overrun <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: frames are serialized at the selected baud,
// expected bytes and error pulses are queued, and a monitor pops them as the DUT reports.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int unsigned F_HZ = 1600000;
    localparam int CLK_NS = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic [1:0] br_cfg;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    typedef enum int {EV_FERR, EV_OVR} ev_e;

    logic [7:0] data_q[$];
    ev_e        ev_q[$];
    logic [7:0] exp_b;
    int         checks = 0;
    int         errors = 0;
    bit         model_full = 1'b0;

    always #(CLK_NS / 2) clk = ~clk;

    uart_rx #(.CLK_FREQ_HZ(F_HZ), .OVERSAMPLE(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .br_cfg    (br_cfg),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    function automatic int bit_ns(input logic [1:0] cfg);
        real baud;
        baud = 4800.0 * (2.0 ** cfg);
        return $rtoi(real'(F_HZ) / (16.0 * baud) + 0.5) * 16 * CLK_NS;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int bits);
        rxd = 1'b1;
        #(bit_ns(br_cfg) * bits);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1;
        rx_ready = v;
        if (v) model_full = 1'b0;
    endtask

    // Reference: a good stop delivers the byte unless the holding slot is occupied.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input bit twiddle);
        int t;
        logic [1:0] keep;
        t = bit_ns(br_cfg);
        keep = br_cfg;
        if (!stop_ok) begin
            ev_q.push_back(EV_FERR);
        end else if (model_full) begin
            ev_q.push_back(EV_OVR);
        end else begin
            data_q.push_back(b);
            if (!rx_ready) model_full = 1'b1;
        end
        rxd = 1'b0;
        #(t);
        if (twiddle) br_cfg = 2'($urandom_range(0, 3));
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            #(t);
        end
        if (stop_ok) begin
            rxd = 1'b1;
            #(t);
        end else begin
            rxd = 1'b0;
            #(t * 3 / 4);
            rxd = 1'b1;
            #(t / 4);
        end
        br_cfg = keep;
    endtask

    // Monitor: every accepted byte and every error pulse must match the queue head.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (rx_valid && rx_ready) begin
                checks++;
                if (data_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte got %02h expected none", rx_data);
                end else begin
                    exp_b = data_q.pop_front();
                    if (rx_data !== exp_b) begin
                        errors++;
                        $display("FAIL rx_data got %02h expected %02h", rx_data, exp_b);
                    end
                end
            end
            if (frame_err) begin
                checks++;
                if (ev_q.size() == 0 || ev_q[0] != EV_FERR) begin
                    errors++;
                    $display("FAIL frame_err got pulse expected no frame_err");
                end else begin
                    void'(ev_q.pop_front());
                end
            end
            if (overrun) begin
                checks++;
                if (ev_q.size() == 0 || ev_q[0] != EV_OVR) begin
                    errors++;
                    $display("FAIL overrun got pulse expected no overrun");
                end else begin
                    void'(ev_q.pop_front());
                end
            end
        end
    end

    initial begin
        int t;
        logic [7:0] rb;
        rst      = 1'b0;
        rxd      = 1'b1;
        rx_ready = 1'b1;
        br_cfg   = 2'b01;
        #40;
        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_rx_valid", 32'(rx_valid), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);
        rst = 1'b1;
        idle(2);

        send_frame(8'h55, 1'b1, 1'b0);
        idle(1);
        send_frame(8'hAA, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'hAA, 1'b1, 1'b0);
        idle(1);

        set_ready(1'b0);
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(1);
        check("held_valid", 32'(rx_valid), 32'h1);
        check("held_data", 32'(rx_data), 32'h55);
        set_ready(1'b1);
        @(posedge clk);
        #1;
        check("valid_drop_after_accept", 32'(rx_valid), 32'h0);

        send_frame(8'h3C, 1'b0, 1'b0);
        idle(2);
        check("ferr_no_valid", 32'(rx_valid), 32'h0);

        t = bit_ns(br_cfg);
        rxd = 1'b0;
        #(t / 8);
        idle(2);
        check("glitch_no_valid", 32'(rx_valid), 32'h0);
        br_cfg = 2'b11;
        send_frame(8'hC3, 1'b1, 1'b0);
        idle(1);

        br_cfg = 2'b01;
        t = bit_ns(br_cfg);
        rxd = 1'b0;
        #(t);
        rb = 8'h81;
        for (int i = 0; i < 4; i++) begin
            rxd = rb[i];
            #(t);
        end
        #(t / 2);
        rst = 1'b0;
        #1;
        check("midreset_rx_data", 32'(rx_data), 32'h00);
        check("midreset_rx_valid", 32'(rx_valid), 32'h0);
        check("midreset_frame_err", 32'(frame_err), 32'h0);
        check("midreset_overrun", 32'(overrun), 32'h0);
        rxd = 1'b1;
        #100;
        rst = 1'b1;
        idle(2);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(1);

        for (int n = 0; n < 12; n++) begin
            br_cfg = 2'($urandom_range(1, 3));
            send_frame(8'($urandom_range(0, 255)), 1'b1, 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 2));
        end
        br_cfg = 2'b10;
        send_frame(8'h5A, 1'b0, 1'b0);
        idle(2);
        send_frame(8'hE7, 1'b1, 1'b1);

        idle(3);
        check("bytes_outstanding", 32'(data_q.size()), 32'd0);
        check("events_outstanding", 32'(ev_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
